fast9_segment_test: RTL

FAST9_SEGMENT_TEST -- requirements
Module: fast9_segment_test

---
 rtl/fast9_segment_test.sv | 303 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fast9_segment_test.sv
// ---------------------------------------------------------------------------
// fast9_segment_test
//
// FAST-9 style segment test on one centre pixel and its 8 ring neighbours.
// The controller writes the 8 neighbour registers and then pulses start.
// The block then runs for a fixed 24 cycles:
//   CLASSIFY (8 cycles) : neighbour k is classed BRIGHT / DARK / SIMILAR
//   SCAN     (15 cycles): circular walk that tracks the longest run of
//                         equal non-similar classes (the wrap is covered by
//                         walking indices 0..7,0..6)
//   DONE     (1 cycle)  : resultValid strobe; the results stay valid until
//                         the next DONE
//
// Optional feature: define FAST9_SCORE_EN to build the corner score
// accumulator. When the macro is not defined, score is tied to 0 and the
// accumulator does not exist.
//
// Ports
//   clock, nReset        : clock, asynchronous active-low reset
//   wrAddr/wrData/wrEn   : neighbour register write port (accepted always)
//   start                : begin an evaluation (ignored while busy)
//   refAddr, centerPix   : centre pixel address/value, sampled with start
//   busy                 : evaluation in progress (CLASSIFY, SCAN, DONE)
//   resultValid          : one-cycle result strobe
//   isCorner, cornerAddr : corner decision and the evaluated refAddr
//   runLen               : longest circular same-class run, clamped to 8
//   overrun              : sticky, start seen while busy
//   score                : corner score (0 without FAST9_SCORE_EN)
// ---------------------------------------------------------------------------
module fast9_segment_test #(
  parameter int THRESH  = 20,
  parameter int RUN_MIN = 5
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic [2:0]  wrAddr,
  input  logic [7:0]  wrData,
  input  logic        wrEn,
  input  logic        start,
  input  logic [14:0] refAddr,
  input  logic [7:0]  centerPix,
  output logic        busy,
  output logic        resultValid,
  output logic        isCorner,
  output logic [14:0] cornerAddr,
  output logic [3:0]  runLen,
  output logic        overrun,
  output logic [10:0] score
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLASSIFY = 2'd1,
    SCAN     = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [8:0] THRESH9  = 9'(THRESH);
  localparam logic [3:0] RUN_MIN4 = 4'(RUN_MIN);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  nbr_q [8];
  logic [7:0]  nbr_d [8];
  logic [7:0]  snap_q [8];
  logic [7:0]  snap_d [8];
  logic [14:0] addr_q, addr_d;
  logic [7:0]  cpix_q, cpix_d;
  logic [7:0]  bright_q, bright_d;
  logic [7:0]  dark_q, dark_d;
  logic [3:0]  brun_q, brun_d;
  logic [3:0]  drun_q, drun_d;
  logic [3:0]  maxrun_q, maxrun_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic        corner_q, corner_d;
  logic [14:0] caddr_q, caddr_d;
  logic [3:0]  runlen_q, runlen_d;
  logic        overrun_q, overrun_d;
`ifdef FAST9_SCORE_EN
  logic [10:0] acc_q, acc_d;
  logic [10:0] score_q, score_d;
  logic [10:0] excess;
`endif

  // Classification of the snapshot pixel selected by the cycle counter.
  // 9-bit limits keep c+t and c-t from wrapping: if c+t overflows 8 bits
  // nothing can be brighter, and if c < t nothing can be darker.
  logic [7:0] cur_pix;
  logic [8:0] hi_lim;
  logic [8:0] lo_lim;
  logic       hi_ok;
  logic       lo_ok;
  logic       is_bright;
  logic       is_dark;

  assign cur_pix   = snap_q[cnt_q[2:0]];
  assign hi_lim    = {1'b0, cpix_q} + THRESH9;
  assign lo_lim    = {1'b0, cpix_q} - THRESH9;
  assign hi_ok     = ~hi_lim[8];
  assign lo_ok     = ({1'b0, cpix_q} >= THRESH9);
  assign is_bright = hi_ok && ({1'b0, cur_pix} > hi_lim);
  assign is_dark   = lo_ok && ({1'b0, cur_pix} < lo_lim);

  // Run tracking for the current scan step (index is i mod 8).
  logic       scan_b;
  logic       scan_d;
  logic [3:0] brun_nx;
  logic [3:0] drun_nx;
  logic [3:0] max_nx;
  logic [3:0] run_clamped;

  assign scan_b      = bright_q[cnt_q[2:0]];
  assign scan_d      = dark_q[cnt_q[2:0]];
  assign brun_nx     = scan_b ? (brun_q + 4'd1) : 4'd0;
  assign drun_nx     = scan_d ? (drun_q + 4'd1) : 4'd0;
  // A uniform ring produces a linear run of 15 over the walk; clamp to 8.
  assign run_clamped = (max_nx > 4'd8) ? 4'd8 : max_nx;

  always_comb begin
    max_nx = maxrun_q;
    if (brun_nx > max_nx) max_nx = brun_nx;
    if (drun_nx > max_nx) max_nx = drun_nx;
  end

`ifdef FAST9_SCORE_EN
  // |p-c|-t for a non-similar pixel; sum of 8 fits in 11 bits.
  always_comb begin
    excess = 11'd0;
    if (is_bright) begin
      excess = 11'(cur_pix) - 11'(cpix_q) - 11'(THRESH);
    end else if (is_dark) begin
      excess = 11'(cpix_q) - 11'(cur_pix) - 11'(THRESH);
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    for (int i = 0; i < 8; i++) begin
      nbr_d[i]  = nbr_q[i];
      snap_d[i] = snap_q[i];
    end
    addr_d    = addr_q;
    cpix_d    = cpix_q;
    bright_d  = bright_q;
    dark_d    = dark_q;
    brun_d    = brun_q;
    drun_d    = drun_q;
    maxrun_d  = maxrun_q;
    valid_d   = 1'b0;
    corner_d  = corner_q;
    caddr_d   = caddr_q;
    runlen_d  = runlen_q;
    overrun_d = overrun_q;
`ifdef FAST9_SCORE_EN
    acc_d     = acc_q;
    score_d   = score_q;
`endif

    // The register file is written in every state; the evaluation only
    // ever looks at the snapshot, so writes cannot disturb it.
    if (wrEn) begin
      nbr_d[wrAddr] = wrData;
    end

    if (start && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          // Snapshot reads nbr_q, so a coincident write lands in the
          // register file but not in this evaluation.
          for (int i = 0; i < 8; i++) begin
            snap_d[i] = nbr_q[i];
          end
          addr_d   = refAddr;
          cpix_d   = centerPix;
          cnt_d    = 4'd0;
          bright_d = 8'd0;
          dark_d   = 8'd0;
          brun_d   = 4'd0;
          drun_d   = 4'd0;
          maxrun_d = 4'd0;
`ifdef FAST9_SCORE_EN
          acc_d    = 11'd0;
`endif
          state_d  = CLASSIFY;
        end
      end

      CLASSIFY: begin
        bright_d[cnt_q[2:0]] = is_bright;
        dark_d[cnt_q[2:0]]   = is_dark;
`ifdef FAST9_SCORE_EN
        acc_d = acc_q + excess;
`endif
        if (cnt_q == 4'd7) begin
          cnt_d   = 4'd0;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      SCAN: begin
        brun_d   = brun_nx;
        drun_d   = drun_nx;
        maxrun_d = max_nx;
        if (cnt_q == 4'd14) begin
          state_d  = DONE;
          valid_d  = 1'b1;
          runlen_d = run_clamped;
          corner_d = (run_clamped >= RUN_MIN4);
          caddr_d  = addr_q;
`ifdef FAST9_SCORE_EN
          score_d  = (run_clamped >= RUN_MIN4) ? acc_q : 11'd0;
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      for (int i = 0; i < 8; i++) begin
        nbr_q[i]  <= 8'd0;
        snap_q[i] <= 8'd0;
      end
      addr_q    <= 15'd0;
      cpix_q    <= 8'd0;
      bright_q  <= 8'd0;
      dark_q    <= 8'd0;
      brun_q    <= 4'd0;
      drun_q    <= 4'd0;
      maxrun_q  <= 4'd0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      corner_q  <= 1'b0;
      caddr_q   <= 15'd0;
      runlen_q  <= 4'd0;
      overrun_q <= 1'b0;
`ifdef FAST9_SCORE_EN
      acc_q     <= 11'd0;
      score_q   <= 11'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      for (int i = 0; i < 8; i++) begin
        nbr_q[i]  <= nbr_d[i];
        snap_q[i] <= snap_d[i];
      end
      addr_q    <= addr_d;
      cpix_q    <= cpix_d;
      bright_q  <= bright_d;
      dark_q    <= dark_d;
      brun_q    <= brun_d;
      drun_q    <= drun_d;
      maxrun_q  <= maxrun_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      corner_q  <= corner_d;
      caddr_q   <= caddr_d;
      runlen_q  <= runlen_d;
      overrun_q <= overrun_d;
`ifdef FAST9_SCORE_EN
      acc_q     <= acc_d;
      score_q   <= score_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign resultValid = valid_q;
  assign isCorner    = corner_q;
  assign cornerAddr  = caddr_q;
  assign runLen      = runlen_q;
  assign overrun     = overrun_q;
`ifdef FAST9_SCORE_EN
  assign score       = score_q;
`else
  assign score       = 11'd0;
`endif

endmodule
